// File: rtl/cdb_reservation_station.sv
// cdb_reservation_station: out-of-order issue queue woken by three result broadcast buses
package cdb_rs_pkg;
  localparam int CDB_PTAG_W = 6;
  typedef struct packed {
    logic valid;
    logic [CDB_PTAG_W-1:0] pd;
  } CDB_t;
endpackage

module cdb_reservation_station
  import cdb_rs_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTAG_W = 6,
  parameter int ROB_W = 4,
  parameter int OP_W = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       dispatch_valid,
  output logic                       dispatch_ready,
  input  logic [OP_W-1:0]            dispatch_op,
  input  logic [PTAG_W-1:0]          dispatch_ps1,
  input  logic                       dispatch_ps1_rdy,
  input  logic [PTAG_W-1:0]          dispatch_ps2,
  input  logic                       dispatch_ps2_rdy,
  input  logic [PTAG_W-1:0]          dispatch_pd,
  input  logic [ROB_W-1:0]           dispatch_rob_idx,
  input  CDB_t                       alu_cdb,
  input  CDB_t                       mul_cdb,
  input  CDB_t                       div_cdb,
  output logic                       issue_valid,
  input  logic                       issue_ready,
  output logic [OP_W-1:0]            issue_op,
  output logic [PTAG_W-1:0]          issue_ps1,
  output logic [PTAG_W-1:0]          issue_ps2,
  output logic [PTAG_W-1:0]          issue_pd,
  output logic [ROB_W-1:0]           issue_rob_idx,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;
  logic [DEPTH-1:0] valid, r1, r2;
  logic [OP_W-1:0] op [DEPTH];
  logic [PTAG_W-1:0] ps1 [DEPTH];
  logic [PTAG_W-1:0] ps2 [DEPTH];
  logic [PTAG_W-1:0] pd [DEPTH];
  logic [ROB_W-1:0] rob [DEPTH];
  logic [IW-1:0] free_idx, sel_idx;
  logic sel_found, do_disp, do_issue;

  function automatic logic wake(input logic [PTAG_W-1:0] t);
    return t != '0 && ((alu_cdb.valid && PTAG_W'(alu_cdb.pd) == t) ||
                       (mul_cdb.valid && PTAG_W'(mul_cdb.pd) == t) ||
                       (div_cdb.valid && PTAG_W'(div_cdb.pd) == t));
  endfunction

  // lowest free slot, lowest ready slot and occupancy, all from registered state
  always_comb begin
    free_idx = '0;
    sel_idx = '0;
    sel_found = 1'b0;
    count = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid[i]) free_idx = IW'(i);
      if (valid[i] && r1[i] && r2[i]) begin
        sel_idx = IW'(i);
        sel_found = 1'b1;
      end
      count = count + CW'(valid[i]);
    end
  end

  assign dispatch_ready = ~&valid;
  assign issue_valid = sel_found && !flush;
  assign do_issue = issue_valid && issue_ready;
  assign do_disp = dispatch_valid && dispatch_ready && !flush;
  assign issue_op = issue_valid ? op[sel_idx] : '0;
  assign issue_ps1 = issue_valid ? ps1[sel_idx] : '0;
  assign issue_ps2 = issue_valid ? ps2[sel_idx] : '0;
  assign issue_pd = issue_valid ? pd[sel_idx] : '0;
  assign issue_rob_idx = issue_valid ? rob[sel_idx] : '0;

  // wakeup, issue retirement and dispatch write; a new source also catches a same-cycle broadcast
  always_ff @(posedge clk) begin
    if (rst || flush) valid <= '0;
    else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wake(ps1[i])) r1[i] <= 1'b1;
        if (wake(ps2[i])) r2[i] <= 1'b1;
      end
      if (do_issue) valid[sel_idx] <= 1'b0;
      if (do_disp) begin
        valid[free_idx] <= 1'b1;
        op[free_idx] <= dispatch_op;
        ps1[free_idx] <= dispatch_ps1;
        ps2[free_idx] <= dispatch_ps2;
        pd[free_idx] <= dispatch_pd;
        rob[free_idx] <= dispatch_rob_idx;
        r1[free_idx] <= dispatch_ps1 == '0 || dispatch_ps1_rdy || wake(dispatch_ps1);
        r2[free_idx] <= dispatch_ps2 == '0 || dispatch_ps2_rdy || wake(dispatch_ps2);
      end
    end
  end
endmodule

// File: tb/tb_cdb_reservation_station.sv
// tb_cdb_reservation_station: directed checks of dispatch, wakeup, bypass, priority, flush and reset
module tb_cdb_reservation_station;
  import cdb_rs_pkg::*;
  logic clk = 1'b0;
  logic rst, flush, dispatch_valid, dispatch_ready, dispatch_ps1_rdy, dispatch_ps2_rdy;
  logic [3:0] dispatch_op, dispatch_rob_idx, issue_op, issue_rob_idx;
  logic [5:0] dispatch_ps1, dispatch_ps2, dispatch_pd, issue_ps1, issue_ps2, issue_pd;
  CDB_t alu_cdb, mul_cdb, div_cdb;
  logic issue_valid, issue_ready;
  logic [3:0] count;
  int errors = 0;
  int checks = 0;

  cdb_reservation_station dut (
    .clk(clk), .rst(rst), .flush(flush),
    .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
    .dispatch_op(dispatch_op), .dispatch_ps1(dispatch_ps1), .dispatch_ps1_rdy(dispatch_ps1_rdy),
    .dispatch_ps2(dispatch_ps2), .dispatch_ps2_rdy(dispatch_ps2_rdy),
    .dispatch_pd(dispatch_pd), .dispatch_rob_idx(dispatch_rob_idx),
    .alu_cdb(alu_cdb), .mul_cdb(mul_cdb), .div_cdb(div_cdb),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_op(issue_op), .issue_ps1(issue_ps1), .issue_ps2(issue_ps2),
    .issue_pd(issue_pd), .issue_rob_idx(issue_rob_idx), .count(count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle();
    dispatch_valid = 1'b0;
    dispatch_op = '0;
    dispatch_ps1 = '0;
    dispatch_ps1_rdy = 1'b0;
    dispatch_ps2 = '0;
    dispatch_ps2_rdy = 1'b0;
    dispatch_pd = '0;
    dispatch_rob_idx = '0;
    alu_cdb = '0;
    mul_cdb = '0;
    div_cdb = '0;
  endtask

  task automatic disp(input logic [3:0] o, input logic [5:0] s1, input logic s1r,
                      input logic [5:0] s2, input logic s2r, input logic [5:0] d, input logic [3:0] rb);
    dispatch_valid = 1'b1;
    dispatch_op = o;
    dispatch_ps1 = s1;
    dispatch_ps1_rdy = s1r;
    dispatch_ps2 = s2;
    dispatch_ps2_rdy = s2r;
    dispatch_pd = d;
    dispatch_rob_idx = rb;
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    issue_ready = 1'b0;
    idle();
    tick();
    tick();
    rst = 1'b0;
    chk("rst_count", count, 0);
    chk("rst_dready", dispatch_ready, 1);
    chk("rst_ivalid", issue_valid, 0);
    chk("rst_ipd", issue_pd, 0);

    issue_ready = 1'b1;
    disp(4'd1, 6'd5, 1'b1, 6'd0, 1'b0, 6'd9, 4'd3);
    tick();
    idle();
    chk("simple_ivalid", issue_valid, 1);
    chk("simple_ipd", issue_pd, 9);
    chk("simple_irob", issue_rob_idx, 3);
    chk("simple_iop", issue_op, 1);
    chk("simple_ips1", issue_ps1, 5);
    chk("simple_count1", count, 1);
    tick();
    chk("simple_count0", count, 0);
    chk("simple_idle", issue_valid, 0);

    disp(4'd2, 6'd7, 1'b0, 6'd0, 1'b0, 6'd10, 4'd4);
    tick();
    idle();
    chk("wake_wait0", issue_valid, 0);
    chk("wake_count", count, 1);
    tick();
    chk("wake_wait1", issue_valid, 0);
    mul_cdb = '{valid: 1'b1, pd: 6'd7};
    #1;
    chk("wake_bcast_cycle", issue_valid, 0);
    tick();
    idle();
    chk("wake_ivalid", issue_valid, 1);
    chk("wake_ipd", issue_pd, 10);
    tick();
    chk("wake_count0", count, 0);

    disp(4'd3, 6'd12, 1'b0, 6'd0, 1'b0, 6'd11, 4'd5);
    alu_cdb = '{valid: 1'b1, pd: 6'd12};
    tick();
    idle();
    chk("bypass_ivalid", issue_valid, 1);
    chk("bypass_ipd", issue_pd, 11);
    tick();
    chk("bypass_count0", count, 0);

    issue_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      disp(4'(i), 6'(20 + i), 1'b0, 6'd0, 1'b0, 6'(30 + i), 4'(i));
      tick();
    end
    idle();
    chk("full_count", count, 8);
    chk("full_dready", dispatch_ready, 0);
    chk("full_ivalid", issue_valid, 0);
    disp(4'd15, 6'd0, 1'b1, 6'd0, 1'b1, 6'd63, 4'd15);
    tick();
    idle();
    chk("ninth_count", count, 8);
    chk("ninth_ivalid", issue_valid, 0);

    alu_cdb = '{valid: 1'b1, pd: 6'd22};
    div_cdb = '{valid: 1'b1, pd: 6'd25};
    tick();
    idle();
    chk("prio_ivalid", issue_valid, 1);
    chk("prio_hold0", issue_pd, 32);
    tick();
    chk("prio_hold1", issue_pd, 32);
    tick();
    chk("prio_hold2", issue_pd, 32);
    chk("prio_hold_rob", issue_rob_idx, 2);
    chk("prio_hold_count", count, 8);
    issue_ready = 1'b1;
    tick();
    chk("prio_second_pd", issue_pd, 35);
    chk("prio_count7", count, 7);
    chk("prio_dready", dispatch_ready, 1);
    tick();
    chk("prio_count6", count, 6);
    chk("prio_empty", issue_valid, 0);

    alu_cdb = '{valid: 1'b1, pd: 6'd20};
    tick();
    idle();
    chk("both_ipd", issue_pd, 30);
    disp(4'd9, 6'd40, 1'b0, 6'd41, 1'b0, 6'd50, 4'd9);
    tick();
    idle();
    chk("both_count", count, 6);
    chk("both_ivalid", issue_valid, 0);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    issue_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      disp(4'd1, 6'(i), 1'b1, 6'd0, 1'b1, 6'(40 + i), 4'(i));
      tick();
    end
    idle();
    chk("pre_flush_count", count, 4);
    chk("pre_flush_ivalid", issue_valid, 1);
    flush = 1'b1;
    issue_ready = 1'b1;
    disp(4'd1, 6'd0, 1'b1, 6'd0, 1'b1, 6'd60, 4'd7);
    #1;
    chk("flush_force_ivalid", issue_valid, 0);
    tick();
    flush = 1'b0;
    idle();
    chk("flush_count", count, 0);
    chk("flush_ivalid", issue_valid, 0);
    chk("flush_dready", dispatch_ready, 1);

    issue_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      disp(4'd2, 6'd0, 1'b1, 6'd0, 1'b1, 6'(44 + i), 4'(i));
      tick();
    end
    idle();
    chk("pre_rst_count", count, 4);
    rst = 1'b1;
    issue_ready = 1'b1;
    disp(4'd2, 6'd0, 1'b1, 6'd0, 1'b1, 6'd61, 4'd8);
    tick();
    rst = 1'b0;
    idle();
    chk("rst2_count", count, 0);
    chk("rst2_ivalid", issue_valid, 0);
    chk("rst2_ipd", issue_pd, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
